// File: rtl/auto_counter_pkg.sv
// Shared digit types, per-digit limits and helpers for the flexible auto counter.
package auto_counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  HEX_MAX = 4'hF;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Highest value a single digit may hold in the selected radix.
    function automatic digit_t digit_max(input logic bcd);
        return bcd ? BCD_MAX : HEX_MAX;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler: asserts step once every tick_div+1 enabled cycles.
module tick_prescaler #(
    parameter int unsigned DIV_BITS = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear_presc,
    input  logic [DIV_BITS-1:0] tick_div,
    output logic                step
);

    logic [DIV_BITS-1:0] presc_q;
    logic [DIV_BITS-1:0] presc_d;

    // >= rather than == so that lowering tick_div mid-count steps immediately.
    assign step = enable && (presc_q >= tick_div);

    always_comb begin
        presc_d = presc_q;
        if (clear_presc || step) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = presc_q + DIV_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/auto_counter_flex.sv
// Free-running N-digit hex/BCD display counter with prescaler, load/clear and wrap/saturate.
module auto_counter_flex
    import auto_counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV_BITS   = 22,
    parameter bit          BCD        = 1'b0,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            clear,
    input  logic                            load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   load_val,
    input  logic                            up_down,
    input  logic [DIV_BITS-1:0]             tick_div,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   digits,
    output logic                            tick,
    output logic                            wrap
);

    localparam int unsigned CNT_W = DIGIT_W * NUM_DIGITS;
    localparam digit_t      DMAX  = digit_max(BCD);

    logic [CNT_W-1:0]      digits_q, digits_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;
    logic                  step;
    logic [CNT_W-1:0]      step_val;
    logic [CNT_W-1:0]      load_clamped;
    logic [NUM_DIGITS:0]   carry;

    tick_prescaler #(
        .DIV_BITS(DIV_BITS)
    ) u_presc (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear_presc(clear | load),
        .tick_div   (tick_div),
        .step       (step)
    );

    // carry[i] means digit i must move; it ripples while digits sit at their limit.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        digit_t cur;
        digit_t nxt;
        digit_t ld;
        logic   at_lim;

        assign cur    = digits_q[i*DIGIT_W +: DIGIT_W];
        assign at_lim = up_down ? (cur == DMAX) : (cur == '0);

        always_comb begin
            nxt = cur;
            if (carry[i]) begin
                if (at_lim) begin
                    nxt = up_down ? digit_t'(0) : DMAX;
                end else begin
                    nxt = up_down ? cur + digit_t'(1) : cur - digit_t'(1);
                end
            end
        end

        assign carry[i+1] = carry[i] & at_lim;
        assign step_val[i*DIGIT_W +: DIGIT_W] = nxt;

        assign ld = load_val[i*DIGIT_W +: DIGIT_W];
        assign load_clamped[i*DIGIT_W +: DIGIT_W] = (BCD && (ld > BCD_MAX)) ? BCD_MAX : ld;
    end

    // Priority: clear > load > step > hold; tick/wrap only pulse on a step.
    always_comb begin
        digits_d = digits_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        if (clear) begin
            digits_d = '0;
        end else if (load) begin
            digits_d = load_clamped;
        end else if (step) begin
            tick_d   = 1'b1;
            wrap_d   = carry[NUM_DIGITS];
            digits_d = (carry[NUM_DIGITS] && SATURATE) ? digits_q : step_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign digits = digits_q;
    assign tick   = tick_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_auto_counter_flex.sv
// Bench for auto_counter_flex: four configurations (hex/BCD x wrap/saturate) against a numeric model.
module tb_auto_counter_flex;

    localparam int ND = 4;
    localparam int DB = 8;
    localparam int NC = 4;  // config index: bit1 = BCD, bit0 = SATURATE

    logic            clk = 1'b0;
    logic            rst, enable, clear, load, up_down;
    logic [15:0]     load_val;
    logic [DB-1:0]   tick_div;
    logic [15:0]     dig [NC];
    logic [NC-1:0]   tk, wr;

    int              n_checks = 0;
    int              n_errors = 0;

    int unsigned     m_val  [NC];
    bit              m_tick [NC];
    bit              m_wrap [NC];
    int unsigned     m_presc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        auto_counter_flex #(
            .NUM_DIGITS(ND),
            .DIV_BITS  (DB),
            .BCD       (1'(g / 2)),
            .SATURATE  (1'(g % 2))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .clear   (clear),
            .load    (load),
            .load_val(load_val),
            .up_down (up_down),
            .tick_div(tick_div),
            .digits  (dig[g]),
            .tick    (tk[g]),
            .wrap    (wr[g])
        );
    end

    function automatic int unsigned base_of(int c);
        return (c >= 2) ? 10 : 16;
    endfunction

    function automatic int unsigned max_of(int c);
        int unsigned m = 1;
        for (int i = 0; i < ND; i++) m = m * base_of(c);
        return m - 1;
    endfunction

    // Numeric count -> displayed digit vector in the config's radix.
    function automatic logic [15:0] enc(int c, int unsigned v);
        logic [15:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(x % base_of(c));
            x = x / base_of(c);
        end
        return r;
    endfunction

    function automatic int unsigned dec_load(int c, logic [15:0] lv);
        int unsigned v = 0;
        int unsigned d;
        for (int i = ND - 1; i >= 0; i--) begin
            d = 32'(lv[i*4 +: 4]);
            if (c >= 2 && d > 9) d = 9;
            v = v * base_of(c) + d;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_val[c] = 0; m_tick[c] = 1'b0; m_wrap[c] = 1'b0;
        end
        m_presc = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit st;
        st = enable && (m_presc >= 32'(tick_div));
        for (int c = 0; c < NC; c++) begin
            m_tick[c] = 1'b0;
            m_wrap[c] = 1'b0;
            if (clear) begin
                m_val[c] = 0;
            end else if (load) begin
                m_val[c] = dec_load(c, load_val);
            end else if (st) begin
                m_tick[c] = 1'b1;
                if (up_down) begin
                    if (m_val[c] == max_of(c)) begin
                        m_wrap[c] = 1'b1;
                        m_val[c]  = (c % 2 == 1) ? max_of(c) : 0;
                    end else m_val[c] = m_val[c] + 1;
                end else begin
                    if (m_val[c] == 0) begin
                        m_wrap[c] = 1'b1;
                        m_val[c]  = (c % 2 == 1) ? 0 : max_of(c);
                    end else m_val[c] = m_val[c] - 1;
                end
            end
        end
        if (clear || load || st) m_presc = 0;
        else if (enable) m_presc = m_presc + 1;
    endtask

    task automatic step_clk();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
        up_down = 1'b1; load_val = '0; tick_div = '0;
        #12;
        model_reset();
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (dig[c] !== 16'h0000 || tk[c] !== 1'b0 || wr[c] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset cfg%0d digits=%h tick=%b wrap=%b required 0000/0/0", c, dig[c], tk[c], wr[c]);
            end
        end
    endtask

    task automatic test_basic_count();
        int first_tick = -1;
        enable = 1'b1; up_down = 1'b1; tick_div = DB'(2);
        rst = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            step_clk();
            if (first_tick < 0 && tk[0] === 1'b1) first_tick = k;
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== enc(c, m_val[c]) || tk[c] !== m_tick[c] || wr[c] !== m_wrap[c]) begin
                    n_errors++;
                    $display("FAIL basic cfg%0d cyc%0d got %h/%b/%b required %h/%b/%b", c, k,
                             dig[c], tk[c], wr[c], enc(c, m_val[c]), m_tick[c], m_wrap[c]);
                end
            end
        end
        n_checks++;
        if (first_tick != 3) begin
            n_errors++;
            $display("FAIL basic_first_tick got cycle %0d required 3", first_tick);
        end
        n_checks++;
        if (dig[0] !== 16'h0010 || dig[2] !== 16'h0016) begin
            n_errors++;
            $display("FAIL basic_16_steps hex=%h bcd=%h required 0010/0016", dig[0], dig[2]);
        end
    endtask

    task automatic test_hex_wrap();
        tick_div = '0; up_down = 1'b1; load = 1'b1; load_val = 16'hFFFE;
        step_clk();
        load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== enc(c, m_val[c]) || tk[c] !== m_tick[c] || wr[c] !== m_wrap[c]) begin
                    n_errors++;
                    $display("FAIL hex_wrap cfg%0d step%0d got %h/%b/%b required %h/%b/%b", c, k,
                             dig[c], tk[c], wr[c], enc(c, m_val[c]), m_tick[c], m_wrap[c]);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (dig[0] !== 16'h0000 || wr[0] !== 1'b1 || dig[1] !== 16'hFFFF || wr[1] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL hex_limit wrapcfg=%h/%b satcfg=%h/%b required 0000/1 FFFF/1", dig[0], wr[0], dig[1], wr[1]);
                end
            end
            if (k == 3) begin
                n_checks++;
                if (dig[0] !== 16'h0001 || wr[0] !== 1'b0 || dig[1] !== 16'hFFFF || wr[1] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL hex_after_limit wrapcfg=%h/%b satcfg=%h/%b required 0001/0 FFFF/1", dig[0], wr[0], dig[1], wr[1]);
                end
            end
        end
    endtask

    task automatic test_bcd_down();
        logic [15:0] exp_bcd [3];
        exp_bcd[0] = 16'h0009; exp_bcd[1] = 16'h0008; exp_bcd[2] = 16'h9999;
        tick_div = '0; up_down = 1'b0; load = 1'b1; load_val = 16'h0010;
        step_clk();
        for (int k = 0; k < 3; k++) begin
            load = (k == 2);
            load_val = 16'h0000;
            if (k == 2) step_clk();
            load = 1'b0;
            step_clk();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== enc(c, m_val[c]) || tk[c] !== m_tick[c] || wr[c] !== m_wrap[c]) begin
                    n_errors++;
                    $display("FAIL bcd_down cfg%0d step%0d got %h/%b/%b required %h/%b/%b", c, k,
                             dig[c], tk[c], wr[c], enc(c, m_val[c]), m_tick[c], m_wrap[c]);
                end
            end
            n_checks++;
            if (dig[2] !== exp_bcd[k]) begin
                n_errors++;
                $display("FAIL bcd_down_value step%0d got %h required %h", k, dig[2], exp_bcd[k]);
            end
        end
        n_checks++;
        if (wr[2] !== 1'b1 || wr[3] !== 1'b1 || dig[3] !== 16'h0000) begin
            n_errors++;
            $display("FAIL bcd_underflow wrap=%b/%b satdigits=%h required 1/1/0000", wr[2], wr[3], dig[3]);
        end
        load = 1'b1; load_val = 16'h00AF;
        step_clk();
        load = 1'b0;
        n_checks++;
        if (dig[2] !== 16'h0099 || dig[3] !== 16'h0099 || dig[0] !== 16'h00AF) begin
            n_errors++;
            $display("FAIL bcd_clamp bcd=%h/%h hex=%h required 0099/0099/00AF", dig[2], dig[3], dig[0]);
        end
    endtask

    task automatic test_priority();
        int cnt = 0;
        enable = 1'b1; up_down = 1'b1; tick_div = DB'(3);
        clear = 1'b1; load = 1'b1; load_val = 16'h1234;
        step_clk();
        n_checks++;
        if (dig[0] !== 16'h0000 || dig[2] !== 16'h0000) begin
            n_errors++;
            $display("FAIL prio_clear_load got %h/%h required 0000", dig[0], dig[2]);
        end
        clear = 1'b0;
        step_clk();
        load = 1'b0;
        n_checks++;
        if (dig[0] !== 16'h1234 || dig[2] !== 16'h1234 || tk !== '0 || wr !== '0) begin
            n_errors++;
            $display("FAIL prio_load got %h/%h tick=%b wrap=%b required 1234 no pulses", dig[0], dig[2], tk, wr);
        end
        do begin
            step_clk();
            cnt++;
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== enc(c, m_val[c]) || tk[c] !== m_tick[c] || wr[c] !== m_wrap[c]) begin
                    n_errors++;
                    $display("FAIL prio_run cfg%0d got %h/%b/%b required %h/%b/%b", c,
                             dig[c], tk[c], wr[c], enc(c, m_val[c]), m_tick[c], m_wrap[c]);
                end
            end
        end while (tk[0] !== 1'b1 && cnt < 20);
        n_checks++;
        if (cnt != 4) begin
            n_errors++;
            $display("FAIL prio_latency got %0d cycles required 4", cnt);
        end
    endtask

    task automatic test_prescaler();
        int cnt = 0;
        logic [15:0] frozen [NC];
        enable = 1'b1; up_down = 1'b1; tick_div = DB'(100); clear = 1'b1;
        step_clk();
        clear = 1'b0;
        for (int k = 0; k < 50; k++) step_clk();
        tick_div = DB'(10);
        step_clk();
        n_checks++;
        if (tk[0] !== 1'b1 || dig[0] !== 16'h0001) begin
            n_errors++;
            $display("FAIL presc_shrink tick=%b digits=%h required 1/0001", tk[0], dig[0]);
        end
        do begin
            step_clk();
            cnt++;
        end while (tk[0] !== 1'b1 && cnt < 40);
        n_checks++;
        if (cnt != 11) begin
            n_errors++;
            $display("FAIL presc_period got %0d cycles required 11", cnt);
        end
        for (int k = 0; k < 5; k++) step_clk();
        for (int c = 0; c < NC; c++) frozen[c] = enc(c, m_val[c]);
        enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step_clk();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== frozen[c] || tk[c] !== 1'b0 || wr[c] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL presc_freeze cfg%0d got %h/%b required %h/0", c, dig[c], tk[c], frozen[c]);
                end
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step_clk();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== enc(c, m_val[c]) || tk[c] !== m_tick[c] || wr[c] !== m_wrap[c]) begin
                    n_errors++;
                    $display("FAIL presc_resume cfg%0d got %h/%b/%b required %h/%b/%b", c,
                             dig[c], tk[c], wr[c], enc(c, m_val[c]), m_tick[c], m_wrap[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        int sel;
        logic [15:0] corner [5];
        corner[0] = 16'hFFFE; corner[1] = 16'h9998; corner[2] = 16'h0000;
        corner[3] = 16'h0001; corner[4] = 16'hFFFF;
        for (int k = 0; k < 500; k++) begin
            clear   = ($urandom_range(0, 49) == 0);
            load    = ($urandom_range(0, 24) == 0);
            enable  = ($urandom_range(0, 7) != 0);
            up_down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) tick_div = DB'($urandom_range(0, 4));
            sel = int'($urandom_range(0, 9));
            load_val = (sel < 5) ? corner[sel] : 16'($urandom);
            step_clk();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== enc(c, m_val[c]) || tk[c] !== m_tick[c] || wr[c] !== m_wrap[c]) begin
                    n_errors++;
                    $display("FAIL random cfg%0d cyc%0d got %h/%b/%b required %h/%b/%b", c, k,
                             dig[c], tk[c], wr[c], enc(c, m_val[c]), m_tick[c], m_wrap[c]);
                end
            end
        end
        clear = 1'b0; load = 1'b0;
    endtask

    task automatic test_async_reset();
        enable = 1'b1; up_down = 1'b1; tick_div = '0;
        load = 1'b1; load_val = 16'h0040;
        step_clk();
        load = 1'b0;
        step_clk();
        step_clk();
        n_checks++;
        if (dig[0] !== 16'h0042 || dig[2] !== 16'h0042 || tk[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_setup got %h/%h tick=%b required 0042/0042/1", dig[0], dig[2], tk[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (dig[c] !== 16'h0000 || tk[c] !== 1'b0 || wr[c] !== 1'b0) begin
                n_errors++;
                $display("FAIL areset cfg%0d got %h/%b/%b required 0000/0/0", c, dig[c], tk[c], wr[c]);
            end
        end
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step_clk();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dig[c] !== enc(c, m_val[c]) || tk[c] !== m_tick[c] || wr[c] !== m_wrap[c]) begin
                    n_errors++;
                    $display("FAIL areset_resume cfg%0d got %h/%b/%b required %h/%b/%b", c,
                             dig[c], tk[c], wr[c], enc(c, m_val[c]), m_tick[c], m_wrap[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_hex_wrap();
        test_bcd_down();
        test_priority();
        test_prescaler();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
